rc_servo_multi_channel: RTL and testbench

- Parametrised N-channel RC servo pulse generator.
- Replaces the single-channel servo FSM plus external timer pair.
- One shared prescaler and period counter serve NUM_CH channels. Each channel has a double-buffered ON time (shadow/active), ON-time clamping and glitch-free enable/disable.
- Sits between the register/command interface (writes) and the servo output pins.

---
 rtl/rc_servo_pkg.sv | 29 ++
 rtl/rc_servo_channel.sv | 65 ++++++
 rtl/rc_servo_multi_channel.sv | 97 +++++++++
 tb/tb_rc_servo_multi_channel.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rc_servo_pkg.sv
// Shared types, default timing constants and the ON-time clamp for the
// multi-channel RC servo pulse generator.
package rc_servo_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_ARMED = 2'd1,
    CH_ON    = 2'd2,
    CH_DONE  = 2'd3
  } ch_state_t;

  localparam int unsigned DEF_NUM_CH       = 8;
  localparam int unsigned DEF_TICK_DIV     = 50;     // 1 us ticks at 50 MHz
  localparam int unsigned DEF_PERIOD_TICKS = 20000;  // 20 ms frame
  localparam int unsigned DEF_ON_W         = 16;
  localparam int unsigned DEF_MIN_ON_TICKS = 500;
  localparam int unsigned DEF_MAX_ON_TICKS = 2500;

  // Zero means "channel silent" and passes through unclamped.
  function automatic int unsigned clamp_on(input int unsigned req,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (req == 0)  return 0;
    if (req < lo)  return lo;
    if (req > hi)  return hi;
    return req;
  endfunction

endpackage

// File: rtl/rc_servo_channel.sv
// One servo channel: shadow/active ON-time registers and the pulse FSM.
// The shared counter position arrives delayed by two cycles to line up with
// the IDLE/DONE -> ARMED -> ON entry latency.
module rc_servo_channel
  import rc_servo_pkg::*;
#(
  parameter int unsigned ON_W  = DEF_ON_W,
  parameter int unsigned CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             period_start,
  input  logic             wr_stb,
  input  logic [ON_W-1:0]  wr_val,
  input  logic             end_tick,
  input  logic [CNT_W-1:0] end_cnt,
  output logic             servo_out,
  output logic             ch_active
);

  localparam int unsigned CMP_W = ((ON_W > CNT_W) ? ON_W : CNT_W) + 1;

  ch_state_t       state_q, state_d;
  logic [ON_W-1:0] shadow_q, shadow_d;
  logic [ON_W-1:0] active_q, active_d;
  logic            end_hit;

  // Counter (two cycles ago) was at active_on-1 on a tick: pulse has lasted
  // exactly active_on*TICK_DIV cycles.
  assign end_hit = end_tick && (CMP_W'(active_q) == CMP_W'(end_cnt) + CMP_W'(1));

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = wr_stb       ? wr_val   : shadow_q;
    active_d = period_start ? shadow_q : active_q;
    unique case (state_q)
      CH_IDLE:  if (period_start && enable) state_d = CH_ARMED;
      CH_ARMED: state_d = (active_q != '0) ? CH_ON : CH_DONE;
      CH_ON:    if (end_hit) state_d = CH_DONE;
      CH_DONE:  if (period_start) state_d = enable ? CH_ARMED : CH_IDLE;
      default:  state_d = CH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= CH_IDLE;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign servo_out = (state_q == CH_ON);
  assign ch_active = (state_q != CH_IDLE);

endmodule

// File: rtl/rc_servo_multi_channel.sv
// N-channel RC servo pulse generator: shared prescaler and frame counter,
// write decode with clamping, and one rc_servo_channel per output pin.
module rc_servo_multi_channel
  import rc_servo_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int unsigned ON_W         = DEF_ON_W,
  parameter int unsigned MIN_ON_TICKS = DEF_MIN_ON_TICKS,
  parameter int unsigned MAX_ON_TICKS = DEF_MAX_ON_TICKS,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ON_W-1:0]   wr_on_time,
  output logic              wr_err,
  output logic              period_start,
  output logic [NUM_CH-1:0] servo_out,
  output logic [NUM_CH-1:0] ch_active
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [CH_W:0] NUM_CH_X = (CH_W + 1)'(NUM_CH);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             tick1_q, tick1_d, tick2_q, tick2_d;
  logic             started_q, started_d;
  logic             wr_err_q, wr_err_d;
  logic             tick;
  logic [ON_W-1:0]  wr_val;

  always_comb begin
    tick      = (pre_q == PRE_W'(TICK_DIV - 1));
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d     = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_W'(PERIOD_TICKS - 1)) ? '0 : cnt_q + CNT_W'(1);
    // The counters sit at 0/0 out of reset; the first frame starts only after
    // one full period has elapsed.
    started_d = started_q | tick;
    tick1_d   = tick;
    tick2_d   = tick1_q;
    cnt1_d    = cnt_q;
    cnt2_d    = cnt1_q;
    wr_err_d  = wr_en && ({1'b0, wr_ch} >= NUM_CH_X);
    wr_val    = ON_W'(clamp_on(32'(wr_on_time), MIN_ON_TICKS, MAX_ON_TICKS));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      tick1_q   <= 1'b0;
      tick2_q   <= 1'b0;
      started_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      tick1_q   <= tick1_d;
      tick2_q   <= tick2_d;
      started_q <= started_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign period_start = started_q && (pre_q == '0) && (cnt_q == '0);
  assign wr_err       = wr_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rc_servo_channel #(
      .ON_W  (ON_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable[i]),
      .period_start (period_start),
      .wr_stb       (wr_en && (wr_ch == CH_W'(i))),
      .wr_val       (wr_val),
      .end_tick     (tick2_q),
      .end_cnt      (cnt2_q),
      .servo_out    (servo_out[i]),
      .ch_active    (ch_active[i])
    );
  end

endmodule

// File: tb/tb_rc_servo_multi_channel.sv
// Directed bench for rc_servo_multi_channel with small timing parameters
// (TICK_DIV=2, PERIOD_TICKS=100, MIN/MAX=10/50); a 3-channel copy exercises wr_err.
module tb_rc_servo_multi_channel;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  enable = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [15:0] wr_on_time = '0;
  logic        wr_err, period_start;
  logic [3:0]  servo_out, ch_active;

  logic [2:0]  enable3 = '0;
  logic        wr_en3 = 1'b0;
  logic [1:0]  wr_ch3 = '0;
  logic [15:0] wr_on3 = '0;
  logic        wr_err3, period_start3;
  logic [2:0]  servo3, act3;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc;
  int w[4];
  int rise[4];
  int w3[3];
  int ps_cnt;
  logic [3:0] act_at0, act_at1, act_last, servo_last;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  rc_servo_multi_channel #(
    .NUM_CH(4), .TICK_DIV(2), .PERIOD_TICKS(100), .ON_W(16),
    .MIN_ON_TICKS(10), .MAX_ON_TICKS(50)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_on_time(wr_on_time), .wr_err(wr_err), .period_start(period_start),
    .servo_out(servo_out), .ch_active(ch_active)
  );

  rc_servo_multi_channel #(
    .NUM_CH(3), .TICK_DIV(2), .PERIOD_TICKS(100), .ON_W(16),
    .MIN_ON_TICKS(10), .MAX_ON_TICKS(50)
  ) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_on_time(wr_on3), .wr_err(wr_err3), .period_start(period_start3),
    .servo_out(servo3), .ch_active(act3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] v);
    wr_en = 1'b1; wr_ch = ch; wr_on_time = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Advance to the next period_start (bounded) and check its cycle number.
  task automatic wait_ps(input string tag, input int exp_cyc);
    int n = 0;
    @(negedge clk);
    while (!period_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ps_seen"}, 32'(period_start), 32'd1);
    chk({tag, "_ps_cycle"}, 32'(cyc), 32'(exp_cyc));
  endtask

  // Observe one 200-cycle frame starting at a period_start negedge, with an
  // optional write and enable change at given frame offsets.
  task automatic frame(input int wr_k, input logic [1:0] wch, input logic [15:0] wv,
                       input int en_k, input logic [3:0] en_v);
    for (int c = 0; c < 4; c++) begin w[c] = 0; rise[c] = -1; end
    for (int c = 0; c < 3; c++) w3[c] = 0;
    ps_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) act_at0 = ch_active;
      if (k == 1) act_at1 = ch_active;
      if (period_start) ps_cnt++;
      for (int c = 0; c < 4; c++)
        if (servo_out[c]) begin
          w[c]++;
          if (rise[c] < 0) rise[c] = k;
        end
      for (int c = 0; c < 3; c++) if (servo3[c]) w3[c]++;
      wr_en = (k == wr_k);
      if (k == wr_k) begin wr_ch = wch; wr_on_time = wv; end
      if (k == en_k) enable = en_v;
    end
    act_last   = ch_active;
    servo_last = servo_out;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_servo", 32'(servo_out), 32'd0);
    chk("rst_active", 32'(ch_active), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    chk("rst_wr_err3", 32'(wr_err3), 32'd0);
    reset = 1'b1;

    // Scenario 1/2 setup: writes on cycles 0..3, ch0 only enabled
    enable = 4'b0001;
    enable3 = 3'b111;
    wr_en3 = 1'b1; wr_ch3 = 2'd0; wr_on3 = 16'd20;
    wr(2'd0, 16'd20);
    wr_en3 = 1'b0;
    wr(2'd1, 16'd5);
    wr(2'd2, 16'd80);
    wr(2'd3, 16'd0);

    // Scenario 5: out-of-range write on the 3-channel copy
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_on3 = 16'd45;
    @(negedge clk);
    wr_en3 = 1'b0;
    chk("wr_err3_pulse", 32'(wr_err3), 32'd1);
    chk("wr_err_main_quiet", 32'(wr_err), 32'd0);
    @(negedge clk);
    chk("wr_err3_one_cycle", 32'(wr_err3), 32'd0);

    // Scenario 1: first frame, enable the rest mid-frame
    wait_ps("f1", 200);
    frame(-1, 2'd0, 16'd0, 50, 4'b1111);
    chk("f1_w0", 32'(w[0]), 32'd40);
    chk("f1_rise0", 32'(rise[0]), 32'd2);
    chk("f1_w1", 32'(w[1]), 32'd0);
    chk("f1_w2", 32'(w[2]), 32'd0);
    chk("f1_w3", 32'(w[3]), 32'd0);
    chk("f1_ps_count", 32'(ps_cnt), 32'd1);
    chk("f1_d3_w0", 32'(w3[0]), 32'd40);
    chk("f1_d3_w1", 32'(w3[1]), 32'd0);
    chk("f1_d3_w2", 32'(w3[2]), 32'd0);

    // Scenario 2: clamping and silent channel
    wait_ps("f2", 400);
    frame(-1, 2'd0, 16'd0, -1, 4'b1111);
    chk("f2_act_at0", 32'(act_at0), 32'h1);
    chk("f2_act_at1", 32'(act_at1), 32'hF);
    chk("f2_w0", 32'(w[0]), 32'd40);
    chk("f2_w1_min_clamp", 32'(w[1]), 32'd20);
    chk("f2_w2_max_clamp", 32'(w[2]), 32'd100);
    chk("f2_w3_zero", 32'(w[3]), 32'd0);
    chk("f2_rise1", 32'(rise[1]), 32'd2);
    chk("f2_rise2", 32'(rise[2]), 32'd2);
    chk("f2_act_end", 32'(act_last), 32'hF);
    chk("f2_servo_end", 32'(servo_last), 32'h0);

    // Scenario 3: write coinciding with period_start
    wait_ps("f3", 600);
    frame(0, 2'd0, 16'd30, -1, 4'b1111);
    chk("f3_w0_old", 32'(w[0]), 32'd40);
    wait_ps("f4", 800);
    frame(150, 2'd0, 16'd20, -1, 4'b1111);
    chk("f4_w0_new", 32'(w[0]), 32'd60);
    chk("f4_w1", 32'(w[1]), 32'd20);

    // Scenario 4: disable 10 cycles into the pulse
    wait_ps("f5", 1000);
    frame(-1, 2'd0, 16'd0, 12, 4'b1110);
    chk("f5_w0_no_runt", 32'(w[0]), 32'd40);
    wait_ps("f6", 1200);
    frame(-1, 2'd0, 16'd0, 50, 4'b1111);
    chk("f6_act0_at_ps", 32'(act_at0[0]), 32'd1);
    chk("f6_act0_after", 32'(act_at1[0]), 32'd0);
    chk("f6_w0", 32'(w[0]), 32'd0);
    chk("f6_w2", 32'(w[2]), 32'd100);

    // Scenario 6: reset mid-pulse
    wait_ps("f7", 1400);
    repeat (20) @(negedge clk);
    chk("f7_mid_pulse", 32'(servo_out[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk("f7_rst_servo", 32'(servo_out), 32'd0);
    chk("f7_rst_active", 32'(ch_active), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_ps("r1", 200);
    frame(0, 2'd0, 16'd25, -1, 4'b1111);
    chk("r1_w0_unwritten", 32'(w[0]), 32'd0);
    chk("r1_w2_unwritten", 32'(w[2]), 32'd0);
    chk("r1_act_at0", 32'(act_at0), 32'h0);
    chk("r1_act_at1", 32'(act_at1), 32'hF);
    wait_ps("r2", 400);
    frame(-1, 2'd0, 16'd0, -1, 4'b1111);
    chk("r2_w0", 32'(w[0]), 32'd50);
    chk("r2_rise0", 32'(rise[0]), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
